// File: rtl/elixirchip_es1_spu_op_mac_multi.sv
// Multi-channel signed multiply-accumulate: registered product, single-cycle RMW of acc[ch],
// then LATENCY-2 output stages. Define ELIXIRCHIP_SPU_MAC_SAT_EN to clamp instead of wrap.
`timescale 1ns / 1ps

module elixirchip_es1_spu_op_mac_multi #(
  parameter int    CHANNELS     = 4,
  parameter int    LATENCY      = 3,
  parameter int    S_DATA0_BITS = 8,
  parameter int    S_DATA1_BITS = 9,
  parameter int    M_DATA_BITS  = 10,
  parameter string DEVICE       = "RTL",
  parameter string SIMULATION   = "false",
  parameter string DEBUG        = "false",
  localparam int   CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cke,
  input  logic        [CH_BITS-1:0]      s_ch,
  input  logic                           s_set,
  input  logic                           s_sub,
  input  logic signed [S_DATA0_BITS-1:0] s_data0,
  input  logic signed [S_DATA1_BITS-1:0] s_data1,
  input  logic                           s_valid,
  output logic        [CH_BITS-1:0]      m_ch,
  output logic signed [M_DATA_BITS-1:0]  m_data,
  output logic                           m_sat,
  output logic                           m_valid
);

  localparam int PROD_BITS = S_DATA0_BITS + S_DATA1_BITS;
  // One guard bit above the wider operand so add/sub never overflows before reduction.
  localparam int FULL_BITS = ((PROD_BITS > M_DATA_BITS) ? PROD_BITS : M_DATA_BITS) + 1;
  localparam int PIPE      = LATENCY - 1;

  logic ch_ok;
  assign ch_ok = (32'(s_ch) < CHANNELS);

  // Stage 1: full-precision product.
  logic                        s1_valid_q;
  logic        [CH_BITS-1:0]   s1_ch_q;
  logic                        s1_set_q;
  logic                        s1_sub_q;
  logic signed [PROD_BITS-1:0] s1_prod_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_set_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_prod_q  <= '0;
    end else if (cke) begin
      s1_valid_q <= s_valid && ch_ok;
      if (s_valid && ch_ok) begin
        s1_ch_q   <= s_ch;
        s1_set_q  <= s_set;
        s1_sub_q  <= s_sub;
        s1_prod_q <= PROD_BITS'(s_data0) * PROD_BITS'(s_data1);
      end
    end
  end

  // Stage 2: read-modify-write of the selected accumulator.
  logic signed [M_DATA_BITS-1:0] acc_q [CHANNELS];
  logic signed [FULL_BITS-1:0]   acc_ext;
  logic signed [FULL_BITS-1:0]   prod_ext;
  logic signed [FULL_BITS-1:0]   sum;
  logic signed [M_DATA_BITS-1:0] s2_data;
  logic                          s2_sat;
`ifdef ELIXIRCHIP_SPU_MAC_SAT_EN
  logic [FULL_BITS-M_DATA_BITS:0] sum_top;
`endif

  always_comb begin
    acc_ext  = FULL_BITS'(acc_q[s1_ch_q]);
    prod_ext = FULL_BITS'(s1_prod_q);
    if (s1_set_q) begin
      sum = prod_ext;
    end else if (s1_sub_q) begin
      sum = acc_ext - prod_ext;
    end else begin
      sum = acc_ext + prod_ext;
    end
`ifdef ELIXIRCHIP_SPU_MAC_SAT_EN
    // In range iff every bit from the result sign bit upward agrees.
    sum_top = sum[FULL_BITS-1:M_DATA_BITS-1];
    if ((&sum_top) || !(|sum_top)) begin
      s2_data = M_DATA_BITS'(sum);
      s2_sat  = 1'b0;
    end else begin
      s2_data = {sum[FULL_BITS-1], {(M_DATA_BITS-1){~sum[FULL_BITS-1]}}};
      s2_sat  = 1'b1;
    end
`else
    s2_data = M_DATA_BITS'(sum);
    s2_sat  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else if (cke && s1_valid_q) begin
      acc_q[s1_ch_q] <= s2_data;
    end
  end

  // Stage 2 result register followed by LATENCY-2 delay stages; last entry drives the outputs.
  logic                          pipe_valid_q [PIPE];
  logic        [CH_BITS-1:0]     pipe_ch_q    [PIPE];
  logic signed [M_DATA_BITS-1:0] pipe_data_q  [PIPE];
  logic                          pipe_sat_q   [PIPE];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_ch_q[i]    <= '0;
        pipe_data_q[i]  <= '0;
        pipe_sat_q[i]   <= 1'b0;
      end
    end else if (cke) begin
      pipe_valid_q[0] <= s1_valid_q;
      if (s1_valid_q) begin
        pipe_ch_q[0]   <= s1_ch_q;
        pipe_data_q[0] <= s2_data;
        pipe_sat_q[0]  <= s2_sat;
      end
      for (int i = 1; i < PIPE; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        if (pipe_valid_q[i-1]) begin
          pipe_ch_q[i]   <= pipe_ch_q[i-1];
          pipe_data_q[i] <= pipe_data_q[i-1];
          pipe_sat_q[i]  <= pipe_sat_q[i-1];
        end
      end
    end
  end

  assign m_valid = pipe_valid_q[PIPE-1];
  assign m_ch    = pipe_ch_q[PIPE-1];
  assign m_data  = pipe_data_q[PIPE-1];
  assign m_sat   = pipe_sat_q[PIPE-1];

endmodule
